// File: rtl/rgb_pkg.sv
// Shared constants, duty typedef and gamma-coefficient helper for the rgb_slew block.
package rgb_pkg;

  localparam int GAMMA_SHIFT      = 24;
  localparam int PWM_INTERVAL_DEF = 1200;
  localparam int W_DEF            = $clog2(PWM_INTERVAL_DEF);

  typedef logic [W_DEF-1:0] duty_t;

  // round(2^GAMMA_SHIFT / pwm_interval), so full-scale maps back onto itself
  function automatic logic [35:0] gamma_k(input int pwm_interval);
    logic [35:0] num;
    num = (36'd1 << GAMMA_SHIFT) + 36'(pwm_interval / 2);
    return num / 36'(pwm_interval);
  endfunction

endpackage

// File: rtl/slew_channel.sv
// One slew-limited duty channel: clamp, bounded step toward target, optional gamma
// output register (enabled by RGB_SLEW_GAMMA_EN).
`default_nettype none

module slew_channel
  import rgb_pkg::*;
#(
  parameter  int PWM_INTERVAL = 1200,
  parameter  int MAX_STEP     = 12,
  localparam int W            = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] target,
  output logic [W-1:0] value,
  output logic         at_target
);

  localparam logic [W:0] FULL     = (W+1)'(PWM_INTERVAL);
  localparam logic [W:0] STEP_LIM = (MAX_STEP >= PWM_INTERVAL) ? FULL : (W+1)'(MAX_STEP);

  // One spare bit keeps the differences free of wrap and underflow.
  logic [W:0] tgt_ext;
  logic [W:0] tgt_c;
  logic [W:0] cur;
  logic [W:0] cur_next;
  logic [W:0] diff;
  logic [W:0] step;

  assign tgt_ext = {1'b0, target};

  always_comb begin
    tgt_c    = (tgt_ext > FULL) ? FULL : tgt_ext;
    diff     = (cur < tgt_c) ? (tgt_c - cur) : (cur - tgt_c);
    step     = (diff > STEP_LIM) ? STEP_LIM : diff;
    cur_next = cur;
    if (tick) begin
      if (cur < tgt_c) begin
        cur_next = cur + step;
      end else if (cur > tgt_c) begin
        cur_next = cur - step;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= '0;
    end else begin
      cur <= cur_next;
    end
  end

`ifdef RGB_SLEW_GAMMA_EN
  localparam logic [35:0] GAMMA_K = gamma_k(PWM_INTERVAL);

  logic [35:0]  gamma_full;
  logic [W-1:0] gamma_q;

  assign gamma_full = 36'(cur) * 36'(cur) * GAMMA_K + (36'd1 << (GAMMA_SHIFT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gamma_q <= '0;
    end else begin
      gamma_q <= W'(gamma_full >> GAMMA_SHIFT);
    end
  end

  // Output lags cur by one clock, so the settled flag is taken from cur itself.
  assign value     = gamma_q;
  assign at_target = (cur == tgt_c);
`else
  assign value     = cur[W-1:0];
  assign at_target = (cur_next == tgt_c);
`endif

endmodule

`default_nettype wire

// File: rtl/rgb_slew.sv
// Three-channel duty slew-rate limiter with a shared update tick; optional gamma
// stage selected with RGB_SLEW_GAMMA_EN.
`default_nettype none

module rgb_slew
  import rgb_pkg::*;
#(
  parameter  int PWM_INTERVAL  = 1200,
  parameter  int STEP_INTERVAL = 12000,
  parameter  int MAX_STEP      = 12,
  localparam int W             = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] red_target,
  input  logic [W-1:0] green_target,
  input  logic [W-1:0] blue_target,
  output logic [W-1:0] red_pwm_value,
  output logic [W-1:0] green_pwm_value,
  output logic [W-1:0] blue_pwm_value,
  output logic         settled
);

  localparam int            CW   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_INTERVAL - 1);

  logic [CW-1:0] count;
  logic          tick;
  logic          red_at;
  logic          green_at;
  logic          blue_at;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  slew_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .MAX_STEP     (MAX_STEP)
  ) u_red (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .target    (red_target),
    .value     (red_pwm_value),
    .at_target (red_at)
  );

  slew_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .MAX_STEP     (MAX_STEP)
  ) u_green (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .target    (green_target),
    .value     (green_pwm_value),
    .at_target (green_at)
  );

  slew_channel #(
    .PWM_INTERVAL (PWM_INTERVAL),
    .MAX_STEP     (MAX_STEP)
  ) u_blue (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .target    (blue_target),
    .value     (blue_pwm_value),
    .at_target (blue_at)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settled <= 1'b0;
    end else begin
      settled <= red_at & green_at & blue_at;
    end
  end

endmodule

`default_nettype wire
